// File: rtl/product_accumulator.sv
// product_accumulator: sums each group of ACC_LEN valid products into one result with an overflow flag.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp the running sum at all-ones instead of wrapping.
module product_accumulator #(
    parameter int DATAWIDTH  = 4,
    parameter int ACC_LEN    = 4,
    parameter int GUARD_BITS = 2,
    localparam int ACCWIDTH  = 2 * DATAWIDTH + GUARD_BITS,
    localparam int CW        = $clog2(ACC_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [2*DATAWIDTH-1:0] i_product,
    input  logic                   i_clear,
    output logic                   o_valid,
    output logic [ACCWIDTH-1:0]    o_sum,
    output logic                   o_overflow,
    output logic [CW-1:0]          o_count
);
    localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
    logic [ACCWIDTH-1:0] acc, acc_d, add_res, sum_d;
    logic [ACCWIDTH:0]   sum;
    logic                ovf_pending, ovf_d, ovf_now, ovf_flag_d, valid_d;
    logic [CW-1:0]       count_d;

    assign sum     = {1'b0, acc} + {{(GUARD_BITS + 1){1'b0}}, i_product};
    assign ovf_now = ovf_pending | sum[ACCWIDTH];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // once any carry has occurred in this group the sum stays pinned at all-ones
    assign add_res = ovf_now ? '1 : sum[ACCWIDTH-1:0];
`else
    assign add_res = sum[ACCWIDTH-1:0];
`endif

    always_comb begin
        acc_d      = acc;
        ovf_d      = ovf_pending;
        count_d    = o_count;
        sum_d      = o_sum;
        ovf_flag_d = o_overflow;
        valid_d    = 1'b0;
        if (i_clear) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else if (i_valid && o_count != LAST) begin
            acc_d   = add_res;
            ovf_d   = ovf_now;
            count_d = o_count + CW'(1);
        end else if (i_valid) begin
            acc_d      = '0;
            ovf_d      = 1'b0;
            count_d    = '0;
            sum_d      = add_res;
            ovf_flag_d = ovf_now;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            ovf_pending <= 1'b0;
            o_count     <= '0;
            o_sum       <= '0;
            o_overflow  <= 1'b0;
            o_valid     <= 1'b0;
        end else begin
            acc         <= acc_d;
            ovf_pending <= ovf_d;
            o_count     <= count_d;
            o_sum       <= sum_d;
            o_overflow  <= ovf_flag_d;
            o_valid     <= valid_d;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench over default, GUARD_BITS=0 and ACC_LEN=1 instances.
module tb_product_accumulator;
    typedef struct {
        int sum;
        bit ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_clear = 1'b0;
    logic [7:0] i_product = 8'd0;
    logic [1:0] sel = 2'd0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       qc[$];

    logic       a_ovalid, a_ovf, b_ovalid, b_ovf, c_ovalid, c_ovf;
    logic [9:0] a_sum, c_sum;
    logic [7:0] b_sum;
    logic [2:0] a_count, b_count;
    logic       c_count;

    always #5 clk = ~clk;

    product_accumulator dut_a (
        .clk(clk), .rst(rst), .i_valid(i_valid && sel == 2'd0), .i_product(i_product),
        .i_clear(i_clear), .o_valid(a_ovalid), .o_sum(a_sum), .o_overflow(a_ovf), .o_count(a_count)
    );

    product_accumulator #(.GUARD_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .i_valid(i_valid && sel == 2'd1), .i_product(i_product),
        .i_clear(i_clear), .o_valid(b_ovalid), .o_sum(b_sum), .o_overflow(b_ovf), .o_count(b_count)
    );

    product_accumulator #(.ACC_LEN(1)) dut_c (
        .clk(clk), .rst(rst), .i_valid(i_valid && sel == 2'd2), .i_product(i_product),
        .i_clear(i_clear), .o_valid(c_ovalid), .o_sum(c_sum), .o_overflow(c_ovf), .o_count(c_count)
    );

    // scoreboard: every result pulse pops the oldest expectation of its instance
    always @(negedge clk) begin
        exp_t e;
        if (a_ovalid) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++; $display("FAIL a_unexpected: o_valid with sum %0d, no result expected", a_sum);
            end else begin
                e = qa.pop_front();
                if ({a_ovf, a_sum} !== {e.ovf, 10'(e.sum)}) begin
                    n_bad++; $display("FAIL a_result: got sum %0d ovf %0b, want sum %0d ovf %0b", a_sum, a_ovf, e.sum, e.ovf);
                end
            end
        end
        if (b_ovalid) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++; $display("FAIL b_unexpected: o_valid with sum %0d, no result expected", b_sum);
            end else begin
                e = qb.pop_front();
                if ({b_ovf, b_sum} !== {e.ovf, 8'(e.sum)}) begin
                    n_bad++; $display("FAIL b_result: got sum %0d ovf %0b, want sum %0d ovf %0b", b_sum, b_ovf, e.sum, e.ovf);
                end
            end
        end
        if (c_ovalid) begin
            n_cmp++;
            if (qc.size() == 0) begin
                n_bad++; $display("FAIL c_unexpected: o_valid with sum %0d, no result expected", c_sum);
            end else begin
                e = qc.pop_front();
                if ({c_ovf, c_sum} !== {e.ovf, 10'(e.sum)}) begin
                    n_bad++; $display("FAIL c_result: got sum %0d ovf %0b, want sum %0d ovf %0b", c_sum, c_ovf, e.sum, e.ovf);
                end
            end
        end
    end

    task automatic drive(input logic v, input int p, input logic c);
        @(posedge clk);
        #1;
        i_valid   = v;
        i_product = 8'(p);
        i_clear   = c;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (a_ovalid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", a_ovalid); end
        n_cmp++; if (a_sum !== 10'd0) begin n_bad++; $display("FAIL reset_sum: got %0d want 0", a_sum); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0b want 0", a_ovf); end
        n_cmp++; if (a_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", a_count); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        int p[8] = '{10, 20, 30, 40, 1, 2, 3, 4};
        int tot = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, i < 8 ? p[i % 8] : 0, 1'b0);
            if (i < 8) begin
                tot += p[i];
                if (i % 4 == 3) begin
                    qa.push_back('{sum: tot % 1024, ovf: tot >= 1024});
                    tot = 0;
                end
            end
            if (i > 0) begin
                n_cmp++; if (a_ovalid !== ((i - 1) % 4 == 3)) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %0b want %0b", i, a_ovalid, (i - 1) % 4 == 3); end
                n_cmp++; if (a_count !== 3'((i > 8 ? 8 : i) % 4)) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, a_count, (i > 8 ? 8 : i) % 4); end
            end
            if (i == 5) begin
                n_cmp++; if (a_sum !== 10'd100) begin n_bad++; $display("FAIL b2b_hold: got %0d want 100", a_sum); end
            end
        end
    endtask

    task automatic test_gaps;
        int p[4] = '{10, 20, 30, 40};
        int g[4] = '{2, 0, 3, 1};
        int pq[$];
        int cnt = 0;
        int tot = 0;
        int n = 0;
        bit prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pq.push_back(p[i]);
            repeat (g[i]) pq.push_back(0);
        end
        pq.push_back(0);
        foreach (pq[i]) begin
            drive(pq[i] != 0, pq[i], 1'b0);
            if (pq[i] != 0) begin
                tot += pq[i];
                n++;
                if (n == 4) qa.push_back('{sum: tot % 1024, ovf: tot >= 1024});
            end
            if (prev) cnt = (cnt + 1) % 4;
            n_cmp++; if (a_count !== 3'(cnt)) begin n_bad++; $display("FAIL gaps_count[%0d]: got %0d want %0d", i, a_count, cnt); end
            n_cmp++; if (a_ovalid !== (prev && cnt == 0)) begin n_bad++; $display("FAIL gaps_valid[%0d]: got %0b want %0b", i, a_ovalid, prev && cnt == 0); end
            prev = pq[i] != 0;
        end
    endtask

    task automatic test_clear;
        logic v[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int   p[8] = '{7, 7, 9, 5, 5, 5, 5, 0};
        logic c[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        int   ec[8] = '{0, 1, 2, 0, 1, 2, 3, 0};
        for (int i = 0; i < 8; i++) begin
            drive(v[i], p[i], c[i]);
            if (i == 6) qa.push_back('{sum: 20, ovf: 1'b0});
            n_cmp++; if (a_count !== 3'(ec[i])) begin n_bad++; $display("FAIL clear_count[%0d]: got %0d want %0d", i, a_count, ec[i]); end
            n_cmp++; if (a_ovalid !== (i == 7)) begin n_bad++; $display("FAIL clear_valid[%0d]: got %0b want %0b", i, a_ovalid, i == 7); end
        end
    endtask

    task automatic test_async_reset;
        int p[4] = '{1, 2, 3, 4};
        repeat (3) drive(1'b1, 6, 1'b0);
        drive(1'b0, 0, 1'b0);
        n_cmp++; if (a_count !== 3'd3) begin n_bad++; $display("FAIL arst_pre_count: got %0d want 3", a_count); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (a_count !== 3'd0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", a_count); end
        n_cmp++; if (a_sum !== 10'd0) begin n_bad++; $display("FAIL arst_sum: got %0d want 0", a_sum); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL arst_ovf: got %0b want 0", a_ovf); end
        n_cmp++; if (a_ovalid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %0b want 0", a_ovalid); end
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, i < 4 ? p[i % 4] : 0, 1'b0);
            if (i == 3) qa.push_back('{sum: 10, ovf: 1'b0});
            n_cmp++; if (a_ovalid !== (i == 4)) begin n_bad++; $display("FAIL arst_valid[%0d]: got %0b want %0b", i, a_ovalid, i == 4); end
        end
    endtask

    task automatic test_overflow;
        int tot = 0;
        int pv;
        sel = 2'd1;
        for (int i = 0; i < 9; i++) begin
            pv = i < 4 ? 225 : (i < 8 ? 1 : 0);
            drive(i < 8, pv, 1'b0);
            tot += pv;
            if (i == 3 || i == 7) begin
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                qb.push_back('{sum: tot >= 256 ? 255 : tot, ovf: tot >= 256});
`else
                qb.push_back('{sum: tot % 256, ovf: tot >= 256});
`endif
                tot = 0;
            end
            n_cmp++; if (b_ovalid !== (i == 4 || i == 8)) begin n_bad++; $display("FAIL ovf_valid[%0d]: got %0b want %0b", i, b_ovalid, i == 4 || i == 8); end
            n_cmp++; if (b_count !== 3'(i % 4)) begin n_bad++; $display("FAIL ovf_count[%0d]: got %0d want %0d", i, b_count, i % 4); end
        end
    endtask

    task automatic test_len1;
        int p[4] = '{9, 3, 0, 0};
        sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            drive(i < 2, p[i], 1'b0);
            if (i < 2) qc.push_back('{sum: p[i], ovf: 1'b0});
            n_cmp++; if (c_ovalid !== (i == 1 || i == 2)) begin n_bad++; $display("FAIL len1_valid[%0d]: got %0b want %0b", i, c_ovalid, i == 1 || i == 2); end
            n_cmp++; if (c_count !== 1'b0) begin n_bad++; $display("FAIL len1_count[%0d]: got %0d want 0", i, c_count); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_clear();
        test_async_reset();
        test_overflow();
        test_len1();
        repeat (2) drive(1'b0, 0, 1'b0);
        n_cmp++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            n_bad++; $display("FAIL drain: %0d results never produced, want 0", qa.size() + qb.size() + qc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
